nibble_frame_rx: RTL and testbench
==================================

# nibble_frame_rx

Serial-to-parallel front end for the 4-bit D-latch stage (`dlatch4`). It receives framed nibbles on a 1-bit serial line (start bit, 4 data bits MSB-first, optional even parity, stop bit). Each good frame drives the latch's `D[3:0]` input and a one-cycle `En` strobe. Bad frames are dropped and flagged, so the latch only ever captures validated data.

## Interface

Parameters:
- `PARITY_EN`, default 1: 1 = frame carries an even-parity bit after the data; 0 = no parity bit.
- `CNT_W`, default 8: width of the good-frame counter.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `sin`  input  1  serial data bit.
- `sin_valid`  input  1  `sin` is sampled only on edges where this is 1.
- `D`  output  4  nibble for the latch; registered.
- `En`  output  1  latch enable strobe; registered, high for exactly one cycle per good frame.
- `frame_err`  output  1  one-cycle pulse on a parity or stop-bit error.
- `busy`  output  1  high while a frame is in progress (state is not IDLE or LOAD).
- `frame_cnt`  output  `CNT_W`  count of good frames; wraps modulo 2^`CNT_W`.

## Operation

- States: IDLE, DATA, PAR, STOP, LOAD.
- Only edges with `sin_valid`=1 advance the frame. When `sin_valid`=0, the FSM holds its state.
- IDLE:
  - A valid `sin`=0 is the start bit: go to DATA and clear the bit counter.
  - A valid `sin`=1 is idle line and is ignored.
- DATA:
  - Each valid bit shifts into an internal 4-bit shift register, MSB first.
  - After the 4th bit, go to PAR if `PARITY_EN`, otherwise go to STOP.
- PAR:
  - The expected bit is the XOR of the 4 data bits.
  - On a match, go to STOP.
  - On a mismatch, pulse `frame_err` and go to IDLE. `D`, `En` and `frame_cnt` are unchanged.
- STOP:
  - A valid `sin`=1 completes a good frame:
    - load `D` with the shift register;
    - set `En`=1;
    - increment `frame_cnt`;
    - go to LOAD.
  - A valid `sin`=0 is a stop error: pulse `frame_err` and go to IDLE.
- LOAD:
  - `En`=1 in this state, and the state lasts one cycle.
  - Next state is IDLE, or DATA if a valid start bit (`sin`=0) arrives in this cycle. This allows back-to-back frames with no idle bit.
- `D` changes only on entry to LOAD. It holds across the cycle in which `En` falls and until the next good frame. This satisfies the latch's requirement of stable `D` at the `En` falling edge.
- The shift register is internal. Partial frames never appear on `D`.
- Reset:
  - Asynchronous assert gives state IDLE, `D`=0, `En`=0, `frame_err`=0, `busy`=0, `frame_cnt`=0, and shift register 0.
  - A reset mid-frame discards the partial frame with no error pulse.

## Timing

- Frame length: 7 valid bits with `PARITY_EN`=1, 6 with `PARITY_EN`=0.
- Latency: `En` and the new `D` are visible in the cycle following the edge that accepts the stop bit, i.e. 0 cycles after that edge with registered outputs. `En` drops at the next edge.
- `frame_err` is high for exactly the one cycle following the edge that accepted the bad bit.
- Gaps of any length in `sin_valid` are allowed within a frame.
- Minimum spacing between `En` pulses: 7 valid cycles, or 6 with `PARITY_EN`=0.
- `frame_cnt` increments on the same edge that raises `En`. From all-ones it wraps to 0.
- `rst` deassertion takes effect at the first `clk` edge after release. No `sin` bit is accepted on an edge where `rst` is high.

## Test plan

- Reset: hold `rst`=1 with random `sin`/`sin_valid` → `D`=0, `En`=0, `frame_err`=0, `busy`=0, `frame_cnt`=0 throughout.
- Good frame, `PARITY_EN`=1, `sin_valid`=1 continuous, bits 0,0,1,1,0,0,1 → `En`=1 for one cycle, `D`=4'b0110, `frame_cnt`=1. Feeding `D`/`En` into `dlatch4` gives `Q`=6.
- Parity error: bits 0,0,0,1,0,0,1 (data 0010, parity 0) → `frame_err` one-cycle pulse, `En` stays 0, `D` unchanged (6), `frame_cnt` unchanged (1).
- Stop error: bits 0,0,1,0,0,1,0 → `frame_err` pulse, no `En`. A following good frame for data 4'b0100 then loads `D`=4 and `frame_cnt`=2.
- Gaps and back-to-back:
  - Send data 0010 with `sin_valid` low for 3 cycles between each bit → `D`=2, one `En` pulse.
  - Then send the start bit of the next frame during the LOAD cycle → that frame is accepted and also loads correctly.
- Reset mid-frame: `rst` pulse after the start bit and 2 data bits → all outputs return to reset values, and a fresh frame received afterwards loads correctly with `frame_cnt`=1.

Source files
------------

// File: rtl/nibble_frame_rx.sv
// Serial framed-nibble receiver feeding a 4-bit D-latch: start bit, 4 data bits MSB-first,
// optional even parity, stop bit. Only validated frames reach D and strobe En.
module nibble_frame_rx #(
    parameter int PARITY_EN = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [3:0]       D,
    output logic             En,
    output logic             frame_err,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAR,
        STOP,
        LOAD
    } state_t;

    state_t           state_reg, state_next;
    logic [3:0]       shift_reg, shift_next;
    logic [1:0]       bit_cnt_reg, bit_cnt_next;
    logic [3:0]       d_reg, d_next;
    logic             en_reg, en_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            d_reg       <= '0;
            en_reg      <= 1'b0;
            err_reg     <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            d_reg       <= d_next;
            en_reg      <= en_next;
            err_reg     <= err_next;
            cnt_reg     <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        d_next       = d_reg;
        cnt_next     = cnt_reg;
        en_next      = 1'b0;
        err_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (sin_valid && !sin) begin
                    state_next   = DATA;
                    bit_cnt_next = 2'd0;
                end
            end
            DATA: begin
                if (sin_valid) begin
                    shift_next   = {shift_reg[2:0], sin};
                    bit_cnt_next = bit_cnt_reg + 2'd1;
                    if (bit_cnt_reg == 2'd3) begin
                        if (PARITY_EN != 0) state_next = PAR;
                        else                state_next = STOP;
                    end
                end
            end
            PAR: begin
                // Even parity: the parity bit equals the XOR of the data bits.
                if (sin_valid) begin
                    if (sin == ^shift_reg) begin
                        state_next = STOP;
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            STOP: begin
                if (sin_valid) begin
                    if (sin) begin
                        d_next     = shift_reg;
                        en_next    = 1'b1;
                        cnt_next   = cnt_reg + 1'b1;
                        state_next = LOAD;
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            LOAD: begin
                // A start bit here is honoured so frames can run back to back.
                if (sin_valid && !sin) begin
                    state_next   = DATA;
                    bit_cnt_next = 2'd0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign D         = d_reg;
    assign En        = en_reg;
    assign frame_err = err_reg;
    assign busy      = (state_reg != IDLE) && (state_reg != LOAD);
    assign frame_cnt = cnt_reg;

endmodule

// File: tb/tb_nibble_frame_rx.sv
// Bench for nibble_frame_rx: directed and randomized frames checked against a frame-level model
// that predicts outcome (good / parity error / stop error) from the frame contents.
module tb_nibble_frame_rx;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          sin;
    logic          sin_valid;
    logic [3:0]    D;
    logic          En;
    logic          frame_err;
    logic          busy;
    logic [CW-1:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    logic [3:0]    exp_d;
    logic [CW-1:0] exp_cnt;
    logic          exp_busy;

    always #5 clk = ~clk;

    nibble_frame_rx #(.PARITY_EN(1), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .D         (D),
        .En        (En),
        .frame_err (frame_err),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_en, input logic e_err);
        check({tag, " En"},        8'(En),        8'(e_en));
        check({tag, " frame_err"}, 8'(frame_err), 8'(e_err));
        check({tag, " D"},         8'(D),         8'(exp_d));
        check({tag, " frame_cnt"}, 8'(frame_cnt), 8'(exp_cnt));
        check({tag, " busy"},      8'(busy),      8'(exp_busy));
    endtask

    // Drive one cycle's inputs at a falling edge, then return at the next falling edge.
    task automatic cycle(input logic s, input logic v);
        sin       = s;
        sin_valid = v;
        @(negedge clk);
    endtask

    // kind: 0 = good frame, 1 = wrong parity bit (stop=1), 2 = stop bit 0.
    task automatic send_frame(input string tag, input logic [3:0] data, input int kind,
                              input int gap_min, input int gap_max);
        logic [6:0] bits;
        logic       par;
        logic       e_en;
        logic       e_err;
        int         gaps;
        par  = ^data;
        bits = {1'b0, data, (kind == 1) ? ~par : par, (kind == 2) ? 1'b0 : 1'b1};
        for (int i = 0; i < 7; i++) begin
            gaps = int'($urandom_range(gap_max, gap_min));
            for (int g = 0; g < gaps; g++) begin
                cycle(1'($urandom), 1'b0);
                check_outputs({tag, " gap"}, 1'b0, 1'b0);
            end
            cycle(bits[6-i], 1'b1);
            if (i <= 4)      exp_busy = 1'b1;
            else if (i == 5) exp_busy = (kind != 1);
            else             exp_busy = 1'b0;
            e_err = (kind == 1 && i == 5) || (kind == 2 && i == 6);
            e_en  = (kind == 0 && i == 6);
            if (e_en) begin
                exp_d   = data;
                exp_cnt = exp_cnt + 1'b1;
            end
            check_outputs($sformatf("%s bit%0d", tag, i), e_en, e_err);
        end
    endtask

    initial begin
        rst       = 1'b1;
        sin       = 1'b1;
        sin_valid = 1'b0;
        exp_d     = 4'h0;
        exp_cnt   = '0;
        exp_busy  = 1'b0;

        // Reset held with random line activity.
        for (int i = 0; i < 6; i++) begin
            sin       = 1'($urandom);
            sin_valid = 1'($urandom);
            @(negedge clk);
            check_outputs("reset_hold", 1'b0, 1'b0);
        end
        rst = 1'b0;
        cycle(1'b1, 1'b1);
        check_outputs("idle_line", 1'b0, 1'b0);

        send_frame("good_0110",    4'b0110, 0, 0, 0);
        send_frame("par_err_0010", 4'b0010, 1, 0, 0);
        send_frame("stop_err_0100", 4'b0100, 2, 0, 0);
        send_frame("good_0100",    4'b0100, 0, 0, 0);
        send_frame("gapped_0010",  4'b0010, 0, 3, 3);
        send_frame("b2b_1011",     4'b1011, 0, 0, 0);
        send_frame("b2b_1111",     4'b1111, 0, 0, 0);

        // Reset after start bit and two data bits.
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        rst = 1'b1;
        #1;
        exp_d    = 4'h0;
        exp_cnt  = '0;
        exp_busy = 1'b0;
        check_outputs("mid_reset", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 1'b0);
        check_outputs("after_reset", 1'b0, 1'b0);
        send_frame("fresh_1001", 4'b1001, 0, 0, 0);

        // Randomized frames; the 3-bit counter wraps several times.
        for (int n = 0; n < 40; n++) begin
            send_frame($sformatf("rand%0d", n), 4'($urandom),
                       ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0, 0, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
